// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - FIFO-fed byte sequencer driving an SPI master's send/done handshake.
// Optional abort-on-stall watchdog is enabled by defining SPI_FEEDER_TIMEOUT_EN.
module spi_tx_feeder #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [8:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     spi_send,
    output logic [7:0]               spi_data_out,
    output logic                     dc_out,
    input  logic                     spi_send_done,
    output logic                     busy,
    output logic                     overflow,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("spi_tx_feeder: DEPTH must be a power of two in 4..64 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_LOW
    } state_t;

    state_t          r_state;
    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync_q;
    logic            r_spi_send;
    logic [7:0]      r_data;
    logic            r_dc;
    logic            r_overflow;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_done_rise;
    logic            w_tmo_hit;

    assign w_full      = (r_level == L_FULL);
    assign w_empty     = (r_level == '0);
    assign w_push      = wr_en & ~w_full;
    assign w_drop      = wr_en & w_full;
    assign w_pop       = (r_state == S_LOAD);
    assign w_done_rise = r_sync2 & ~r_sync_q;

    // Storage carries no reset: clearing the pointers is what discards its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_sync1  <= spi_send_done;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
        end
    end

`ifdef SPI_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] L_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout_err;
    logic          w_in_flight;

    assign w_in_flight = (r_state == S_SEND) || (r_state == S_WAIT_LOW);
    assign w_tmo_hit   = w_in_flight && (r_tmo_cnt == L_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_tmo_cnt <= '0;
            end else if (w_in_flight && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_hit) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (err_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_spi_send <= 1'b0;
            r_data     <= 8'h00;
            r_dc       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    {r_dc, r_data} <= r_mem[r_rd_ptr];
                    r_spi_send     <= 1'b1;
                    r_state        <= S_SEND;
                end
                S_SEND: begin
                    if (w_tmo_hit) begin
                        r_spi_send <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_done_rise) begin
                        r_spi_send <= 1'b0;
                        r_state    <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    // Hold off the next byte until the master has finished its done period.
                    if (w_tmo_hit || !r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_spi_send <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign level        = r_level;
    assign spi_send     = r_spi_send;
    assign spi_data_out = r_data;
    assign dc_out       = r_dc;
    assign busy         = (r_state != S_IDLE);
    assign overflow     = r_overflow;

endmodule
